button_debounce: RTL and testbench
==================================

# button_debounce

Per-channel synchronizer and debouncer for the raw push-button inputs on the SoC fabric. It sits directly upstream of the button PIO and drives the PIO's `in_port`. It delivers a clean, glitch-free, clock-domain-safe level whose polarity matches the raw pins (active-low, released = 1), so the PIO's falling-edge capture sees exactly one edge per physical press. It also provides single-cycle press/release strobes for fabric logic that does not go through the PIO.

## Interface
Parameters:
- `NUM_BTN`, 4: number of button channels.
- `DEBOUNCE_CYCLES`, 500000: cycles the synchronized input must stay stable before the output follows (10 ms at 50 MHz). Legal range 2 … 2^24−1.
- `LONG_CYCLES`, 100000000: hold time for the long-press strobe (only with the macro, see Configuration).

Ports:
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `btn_raw`, input, `NUM_BTN`: asynchronous button pins, active-low.
- `btn_db`, output, `NUM_BTN`: debounced level, active-low; connects to the PIO `in_port`.
- `press_pulse`, output, `NUM_BTN`: one-cycle strobe when `btn_db[i]` goes 1→0.
- `release_pulse`, output, `NUM_BTN`: one-cycle strobe when `btn_db[i]` goes 0→1.
- `long_press`, output, `NUM_BTN`: one-cycle strobe for a long press; tied to 0 when the feature is compiled out.

## Operation
- Each channel has a 2-flop synchronizer (`s1`, `s2`), then a 4-state FSM with a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`.
- FSM states:
  - `REL` (btn_db=1):
    - `s2`=0 → `PEND_PRESS`, cnt=1.
  - `PEND_PRESS` (btn_db=1):
    - `s2`=1 → `REL`, cnt=0 (bounce; discard).
    - Else if cnt==`DEBOUNCE_CYCLES` → `PRESSED`, btn_db←0, press_pulse=1 for one cycle, cnt=0.
    - Else cnt++.
  - `PRESSED` (btn_db=0):
    - `s2`=1 → `PEND_REL`, cnt=1.
  - `PEND_REL` (btn_db=0): mirror of `PEND_PRESS`.
    - `s2`=0 → `PRESSED`.
    - Else if cnt==`DEBOUNCE_CYCLES` → `REL`, btn_db←1, release_pulse=1.
- Any disagreement during a pending state restarts the qualification; the output never toggles on a pulse shorter than `DEBOUNCE_CYCLES`.
- All outputs are registered. Pulses are registered alongside the `btn_db` change and land in the same cycle as it.
- Channels are fully independent. Simultaneous events on different channels are each handled in the same cycle.
- The counter saturates by construction (leaves the pending state at terminal count), so it never wraps.

## Timing
- Reset values:
  - `s1`, `s2` = all 1.
  - State = `REL`, cnt = 0.
  - `btn_db` = all 1.
  - `press_pulse`, `release_pulse`, `long_press` = 0.
- Because `btn_db` resets to released, no edge is presented to the PIO after reset.
- Latency: a raw change held stable reaches `btn_db` exactly 2 + `DEBOUNCE_CYCLES` rising edges after the edge that first samples it into `s1`.
- Reset asserted mid-qualification returns the channel to `REL` immediately (asynchronous) and aborts any pending pulse. A button held through reset is re-qualified as a fresh press after release of reset.
- Pulse width is exactly 1 cycle. Consecutive presses are separated by at least 2·`DEBOUNCE_CYCLES` cycles.

## Configuration
- Macro: `BUTTON_DEBOUNCE_LONGPRESS_EN`.
- Defined:
  - Each channel adds a hold counter that starts at the `press_pulse` cycle and counts while in `PRESSED`/`PEND_REL`.
  - When it reaches `LONG_CYCLES`, `long_press[i]`=1 for one cycle, once per press.
  - The counter clears on the transition to `REL`.
- Undefined: no hold counter is built and `long_press` is constant 0. All other behaviour is identical.

## Structure
- Package `button_debounce_pkg`:
  - State enum `db_state_t` {`REL`, `PEND_PRESS`, `PRESSED`, `PEND_REL`}.
  - Function for counter width.
  - Default constants `DB_CYCLES_DEFAULT`, `LONG_CYCLES_DEFAULT`.
- One sub-module, `button_debounce_chan`: a single channel (synchronizer, FSM, optional hold counter).
- The top level is a generate loop of `NUM_BTN` instances.

## Test plan
Use `DEBOUNCE_CYCLES`=8 and `LONG_CYCLES`=40 on the bench, with the macro defined and then undefined.
1. Reset: hold `btn_raw`=4'b0000 through reset → `btn_db`=4'b1111 and no pulses while reset is asserted. After release, `btn_db[i]` falls 10 cycles later, with one `press_pulse` per channel.
2. Clean press: `btn_raw[0]` 1→0 and held → `btn_db[0]`=0 exactly 10 cycles after first sample, `press_pulse[0]` high for 1 cycle. Release → `btn_db[0]`=1 after 10 cycles with `release_pulse[0]`.
3. Bounce: toggle `btn_raw[1]` with low pulses of 3, 5, 7 cycles, then hold low → no output change during the bounce. A single press is reported 10 cycles after the final stable low begins.
4. Simultaneous: channels 2 and 3 pressed in the same cycle → both `press_pulse` bits are asserted in the same cycle. Channel 3 release during channel 2's qualification does not disturb channel 2.
5. Mid-operation reset: assert `reset_n`=0 at cnt=5 of a pending press → outputs return to reset values immediately. No pulse is emitted afterwards unless the button is re-qualified.
6. Long press (macro on): hold for 60 cycles → exactly one `long_press[0]` strobe, 40 cycles after `press_pulse[0]`. With the macro off, `long_press` stays 0.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package button_debounce_pkg;

   // Channel qualification states. The debounced level is 1 in REL/PEND_PRESS
   // and 0 in PRESSED/PEND_REL.
   typedef enum logic [1:0] {
      REL        = 2'd0,
      PEND_PRESS = 2'd1,
      PRESSED    = 2'd2,
      PEND_REL   = 2'd3
   } db_state_t;

   // 10 ms at 50 MHz.
   localparam int unsigned DB_CYCLES_DEFAULT   = 500000;
   // 2 s at 50 MHz.
   localparam int unsigned LONG_CYCLES_DEFAULT = 100000000;

   // Bits needed to hold a count from 0 up to and including max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, 4-state qualification FSM and,
// when BUTTON_DEBOUNCE_LONGPRESS_EN is defined, a long-press hold counter.
// Pin and output polarity are active-low (released = 1).
module button_debounce_chan
   import button_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DB_CYCLES_DEFAULT,
   parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw_i,
   output logic btn_db_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          s1_q, s2_q;
   db_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d;
   logic          press_q, press_d;
   logic          rel_q, rel_d;

   // Bring the asynchronous pin into the clock domain; resets to released.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= btn_raw_i;
         s2_q <= s1_q;
      end
   end

   // Qualification FSM: the output only follows s2 after it has disagreed with
   // the output for DEBOUNCE_CYCLES+1 consecutive samples; any agreement aborts.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
         REL: begin
            if (!s2_q) begin
               state_d = PEND_PRESS;
               cnt_d   = CNT_ONE;
            end
         end
         PEND_PRESS: begin
            if (s2_q) begin
               state_d = REL;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TERM) begin
               state_d = PRESSED;
               db_d    = 1'b0;
               press_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            if (s2_q) begin
               state_d = PEND_REL;
               cnt_d   = CNT_ONE;
            end
         end
         PEND_REL: begin
            if (!s2_q) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TERM) begin
               state_d = REL;
               db_d    = 1'b1;
               rel_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = REL;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM state, counter and registered outputs; pulses land with the level change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= REL;
         cnt_q   <= '0;
         db_q    <= 1'b1;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign btn_db_o  = db_q;
   assign press_o   = press_q;
   assign release_o = rel_q;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
   localparam int unsigned HW = cnt_width(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_TERM = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CYCLES - 1);

   logic [HW-1:0] hold_q, hold_d;
   logic          long_q, long_d;
   logic          held;

   assign held = (state_q == PRESSED) || (state_q == PEND_REL);

   // Hold counter: zero on the press cycle, counts while held, saturates so the
   // strobe fires once per press, and clears when the channel returns to REL.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (press_d) begin
         hold_d = '0;
      end else if (held && (hold_q != HOLD_TERM)) begin
         hold_d = hold_q + HW'(1);
         long_d = (hold_q == HOLD_PRE);
      end
      if (rel_d) hold_d = '0;
   end

   // Hold counter and long-press strobe registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_o = long_q;
`else
   // Feature compiled out: constant 0; LONG_CYCLES only shapes the enabled build.
   assign long_o = (LONG_CYCLES > 0) && 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button synchronizer/debouncer feeding the button PIO.
// Optional long-press strobe: define BUTTON_DEBOUNCE_LONGPRESS_EN.
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int unsigned NUM_BTN         = 4,
   parameter int unsigned DEBOUNCE_CYCLES = DB_CYCLES_DEFAULT,
   parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_db,
   output logic [NUM_BTN-1:0] press_pulse,
   output logic [NUM_BTN-1:0] release_pulse,
   output logic [NUM_BTN-1:0] long_press
);

   // Channels are fully independent; one instance per button.
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      button_debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_chan (
         .clk       (clk),
         .reset_n   (reset_n),
         .btn_raw_i (btn_raw[i]),
         .btn_db_o  (btn_db[i]),
         .press_o   (press_pulse[i]),
         .release_o (release_pulse[i]),
         .long_o    (long_press[i])
      );
   end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (DEBOUNCE_CYCLES=8, LONG_CYCLES=40).
// Build with and without BUTTON_DEBOUNCE_LONGPRESS_EN.
module tb_button_debounce;
   localparam int NB = 4;
   localparam int DC = 8;
   localparam int LC = 40;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [NB-1:0] btn_raw = '0;
   logic [NB-1:0] btn_db, press_pulse, release_pulse, long_press;

   always #5 clk = ~clk;

   button_debounce #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .btn_raw       (btn_raw),
      .btn_db        (btn_db),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press)
   );

   typedef struct {int cyc; int ch; int kind;} ev_t;  // kind 0 press, 1 release, 2 long
   ev_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: the debounced level flips once the last DC+1 synchronized
   // pin samples (pin as sampled two edges earlier) all differ from it.
   logic [NB-1:0] db_m;
   logic [15:0]   hist [NB];   // hist[c][k] = pin sampled k+1 edges ago
   int            press_t [NB];

   task automatic model_reset();
      db_m = '1;
      for (int c = 0; c < NB; c++) begin
         hist[c]    = '1;
         press_t[c] = 0;
      end
   endtask

   task automatic model_step();
      cyc++;
      for (int c = 0; c < NB; c++) begin
         bit all_dis, was, ev_p, ev_r, ev_l;
         ev_t e;
         all_dis = 1'b1;
         for (int j = 0; j <= DC; j++)
            if (hist[c][1+j] == db_m[c]) all_dis = 1'b0;
         was  = db_m[c];
         ev_p = all_dis && was;
         ev_r = all_dis && !was;
         ev_l = 1'b0;
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
         ev_l = !was && (cyc - press_t[c] == LC);
`endif
         if (all_dis) db_m[c] = ~was;
         if (ev_p) begin press_t[c] = cyc; e = '{cyc, c, 0}; exp_q.push_back(e); end
         if (ev_r) begin e = '{cyc, c, 1}; exp_q.push_back(e); end
         if (ev_l) begin e = '{cyc, c, 2}; exp_q.push_back(e); end
         hist[c] = {hist[c][14:0], btn_raw[c]};
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else          model_step();
      end
   end

   // Monitor: compares the level every cycle and pops one expected event for
   // every strobe the DUT presents.
   initial begin
      forever begin
         @(negedge clk);
         n_checks++;
         if (btn_db !== db_m) begin
            n_fail++;
            $display("FAIL btn_db cyc=%0d got=%b exp=%b", cyc, btn_db, db_m);
         end
`ifndef BUTTON_DEBOUNCE_LONGPRESS_EN
         n_checks++;
         if (long_press !== '0) begin
            n_fail++;
            $display("FAIL long_off cyc=%0d got=%b exp=0", cyc, long_press);
         end
`endif
         for (int c = 0; c < NB; c++) begin
            for (int k = 0; k < 3; k++) begin
               logic v;
               v = (k == 0) ? press_pulse[c] : (k == 1) ? release_pulse[c] : long_press[c];
               if (v !== 1'b0) begin
                  n_checks++;
                  if (exp_q.size() == 0) begin
                     n_fail++;
                     $display("FAIL unexpected_event cyc=%0d ch=%0d kind=%0d", cyc, c, k);
                  end else begin
                     ev_t e;
                     e = exp_q.pop_front();
                     if (e.cyc != cyc || e.ch != c || e.kind != k) begin
                        n_fail++;
                        $display("FAIL event got cyc=%0d ch=%0d kind=%0d exp cyc=%0d ch=%0d kind=%0d",
                                 cyc, c, k, e.cyc, e.ch, e.kind);
                     end
                  end
               end
            end
         end
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            ev_t e;
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_event cyc=%0d got=none exp ch=%0d kind=%0d at cyc=%0d",
                     cyc, e.ch, e.kind, e.cyc);
         end
      end
   end

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if ({btn_db, press_pulse, release_pulse, long_press} !== {{NB{1'b1}}, {(3*NB){1'b0}}}) begin
         n_fail++;
         $display("FAIL %s got db=%b pp=%b rp=%b lp=%b exp db=1111 pulses=0",
                  name, btn_db, press_pulse, release_pulse, long_press);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // 1: buttons held through reset
      btn_raw = '0;
      wait_neg(2);
      check_reset_outputs("reset_hold");
      wait_neg(3);
      check_reset_outputs("reset_hold_late");
      reset_n = 1'b1;
      wait_neg(20);
      btn_raw = '1;
      wait_neg(20);

      // 2: clean press / release on ch0
      btn_raw[0] = 1'b0;
      wait_neg(15);
      btn_raw[0] = 1'b1;
      wait_neg(15);

      // 3: bounce on ch1 with 3/5/7-cycle lows, then a stable low
      for (int p = 3; p <= 7; p += 2) begin
         btn_raw[1] = 1'b0;
         wait_neg(p);
         btn_raw[1] = 1'b1;
         wait_neg(3);
      end
      btn_raw[1] = 1'b0;
      wait_neg(15);
      btn_raw[1] = 1'b1;
      wait_neg(15);

      // 4: ch2/ch3 pressed together, ch3 released while ch2 is qualifying
      btn_raw[3:2] = 2'b00;
      wait_neg(12);
      btn_raw[2] = 1'b1;
      wait_neg(4);
      btn_raw[3] = 1'b1;
      wait_neg(20);

      // 5: reset at cnt=5 of a pending press; pin released during reset
      btn_raw[0] = 1'b0;
      repeat (7) @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("mid_reset");
      btn_raw[0] = 1'b1;
      wait_neg(3);
      check_reset_outputs("mid_reset_hold");
      reset_n = 1'b1;
      wait_neg(20);

      // 6: long hold on ch0
      btn_raw[0] = 1'b0;
      wait_neg(72);
      btn_raw[0] = 1'b1;
      wait_neg(20);

      // randomized toggling on all channels
      for (int i = 0; i < 300; i++) begin
         int c;
         c = $urandom_range(NB - 1, 0);
         btn_raw[c] = ~btn_raw[c];
         wait_neg($urandom_range(14, 1));
      end
      btn_raw = '1;
      wait_neg(30);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
